// File: rtl/xgmii_rx_deframer_if.sv
// xgmii_rx_deframer_if
//   Bundles the XGMII receive lanes and the rebuilt packet stream of the
//   xgmii_rx_deframer into one interface.
//   master : the deframer side. It takes in xgmii_rxd/xgmii_rxc and drives
//            pkt_rx_* and the packet/error counters.
//   slave  : the feeding/observing side. It drives the XGMII lanes and
//            receives the packet stream.
//   Signals:
//     xgmii_rxd   64     lane k = bits [8k+7:8k], lane 0 first on the wire
//     xgmii_rxc   8      bit k set: lane k carries a control character
//     pkt_rx_val  1      output word valid (one-cycle pulse per word)
//     pkt_rx_sop  1      first word of packet
//     pkt_rx_eop  1      last word of packet
//     pkt_rx_mod  3      valid bytes in the eop word, 0 = all 8
//     pkt_rx_data 64     lane 0 byte in [63:56], lane 7 byte in [7:0]
//     pkt_rx_err  1      packet errored, only together with eop
//     pkt_cnt     CNT_W  good packets, saturating
//     err_cnt     CNT_W  error events, saturating
interface xgmii_rx_deframer_if #(
  parameter int CNT_W = 16
) ();
  logic [63:0]      xgmii_rxd;
  logic [7:0]       xgmii_rxc;
  logic             pkt_rx_val;
  logic             pkt_rx_sop;
  logic             pkt_rx_eop;
  logic [2:0]       pkt_rx_mod;
  logic [63:0]      pkt_rx_data;
  logic             pkt_rx_err;
  logic [CNT_W-1:0] pkt_cnt;
  logic [CNT_W-1:0] err_cnt;

  modport master (
    input  xgmii_rxd, xgmii_rxc,
    output pkt_rx_val, pkt_rx_sop, pkt_rx_eop, pkt_rx_mod, pkt_rx_data, pkt_rx_err,
    output pkt_cnt, err_cnt
  );

  modport slave (
    output xgmii_rxd, xgmii_rxc,
    input  pkt_rx_val, pkt_rx_sop, pkt_rx_eop, pkt_rx_mod, pkt_rx_data, pkt_rx_err,
    input  pkt_cnt, err_cnt
  );
endinterface

// File: rtl/xgmii_rx_deframer.sv
// xgmii_rx_deframer
//   Rebuilds a val/sop/eop/mod/data packet stream from a 64-bit XGMII receive
//   stream. Start/preamble/SFD and Terminate are stripped, framing problems are
//   flagged on the eop word, and saturating packet/error counters are kept.
//   There is no backpressure: every XGMII word is consumed on its clock edge.
//   Ports:
//     clk_156m25      single clock, all logic on the rising edge
//     reset_156m25_n  asynchronous active-low reset
//     bus             xgmii_rx_deframer_if.master (XGMII in, packet stream and
//                     counters out)
//   A one-word hold register gives lookahead so the last data word can be
//   tagged eop once the Terminate arrives. Fixed latency: a word sampled on
//   edge n is presented on pkt_rx_* after edge n+1.
module xgmii_rx_deframer #(
  parameter int CNT_W = 16
) (
  input  logic                clk_156m25,
  input  logic                reset_156m25_n,
  xgmii_rx_deframer_if.master bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DATA  = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  localparam logic [7:0]  CH_IDLE    = 8'h07;
  localparam logic [7:0]  CH_START   = 8'hFB;
  localparam logic [7:0]  CH_TERM    = 8'hFD;
  localparam logic [63:0] START_WORD = 64'hD5555555555555FB;

  // Lane decode
  logic [7:0]  rx_lane [8];
  logic [63:0] rx_swapped;
  logic [7:0]  lane_idle;
  logic [7:0]  term_hit;
  logic [7:0]  trail_ok;

  for (genvar gi = 0; gi < 8; gi++) begin : g_lane
    // rxc pattern of a Terminate in lane gi, and the mask of lanes above it
    localparam logic [7:0] TERM_RXC = 8'(8'hFF << gi);
    localparam logic [7:0] UPPER    = 8'(8'hFE << gi);

    assign rx_lane[gi]               = bus.xgmii_rxd[8*gi +: 8];
    assign rx_swapped[63-8*gi -: 8]  = rx_lane[gi];
    assign lane_idle[gi]             = (rx_lane[gi] == CH_IDLE);
    assign term_hit[gi]              = (bus.xgmii_rxc == TERM_RXC) && (rx_lane[gi] == CH_TERM);
    assign trail_ok[gi]              = ((lane_idle & UPPER) == UPPER);
  end

  logic        is_data;
  logic        is_start_pat;
  logic        is_start_ok;
  logic        is_term;
  logic [2:0]  term_k;
  logic        term_clean;
  logic [63:0] term_partial;

  assign is_data      = (bus.xgmii_rxc == 8'h00);
  assign is_start_pat = (bus.xgmii_rxc == 8'h01) && (rx_lane[0] == CH_START);
  assign is_start_ok  = is_start_pat && (bus.xgmii_rxd == START_WORD);
  assign is_term      = |term_hit;

  // At most one term_hit bit can be set, since each lane has its own rxc pattern.
  always_comb begin
    term_k     = '0;
    term_clean = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (term_hit[i]) begin
        term_k     = 3'(i);
        term_clean = trail_ok[i];
      end
    end
  end

  // Keep only the term_k payload bytes ahead of the Terminate, already in output byte order
  assign term_partial = rx_swapped & ~(64'hFFFF_FFFF_FFFF_FFFF >> {term_k, 3'b000});

  // State
  logic [1:0]       state_q, state_d;
  logic [63:0]      hold_data_q, hold_data_d;
  logic             hold_vld_q, hold_vld_d;
  logic             hold_sop_q, hold_sop_d;
  logic             sop_pend_q, sop_pend_d;
  logic             err_acc_q, err_acc_d;
  logic [2:0]       flush_mod_q, flush_mod_d;

  logic             val_q, val_d;
  logic             sop_q, sop_d;
  logic             eop_q, eop_d;
  logic [2:0]       mod_q, mod_d;
  logic [63:0]      data_q, data_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic             emit;
  logic             emit_eop;
  logic             emit_err;
  logic [2:0]       emit_mod;
  logic             extra_err;
  logic             idle_in;
  logic [1:0]       err_inc;
  logic             pkt_inc;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [1:0] inc);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {{(CNT_W-1){1'b0}}, inc};
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  always_comb begin
    state_d     = state_q;
    hold_data_d = hold_data_q;
    hold_vld_d  = hold_vld_q;
    hold_sop_d  = hold_sop_q;
    sop_pend_d  = sop_pend_q;
    err_acc_d   = err_acc_q;
    flush_mod_d = flush_mod_q;
    emit        = 1'b0;
    emit_eop    = 1'b0;
    emit_err    = 1'b0;
    emit_mod    = '0;
    extra_err   = 1'b0;
    idle_in     = 1'b0;

    case (state_q)
      ST_DATA: begin
        if (is_term && (term_k == 3'd0)) begin
          // Terminate in lane 0: the held word is the last one. With nothing
          // held the packet had no payload at all.
          if (hold_vld_q) begin
            emit     = 1'b1;
            emit_eop = 1'b1;
            emit_err = err_acc_q | ~term_clean;
          end else begin
            extra_err = 1'b1;
          end
          hold_vld_d = 1'b0;
          err_acc_d  = 1'b0;
          state_d    = ST_IDLE;
        end else if (is_term) begin
          // Partial last word: push out the previous word, keep the tail for FLUSH
          emit        = hold_vld_q;
          hold_data_d = term_partial;
          hold_vld_d  = 1'b1;
          hold_sop_d  = sop_pend_q;
          sop_pend_d  = 1'b0;
          err_acc_d   = err_acc_q | ~term_clean;
          flush_mod_d = term_k;
          state_d     = ST_FLUSH;
        end else if (is_start_ok) begin
          // Start inside a packet: close the current one as errored and open a new one
          if (hold_vld_q) begin
            emit     = 1'b1;
            emit_eop = 1'b1;
            emit_err = 1'b1;
          end else begin
            extra_err = 1'b1;
          end
          hold_vld_d = 1'b0;
          sop_pend_d = 1'b1;
          err_acc_d  = 1'b0;
        end else begin
          // Data word, or stray control treated as data that poisons the packet
          emit        = hold_vld_q;
          hold_data_d = rx_swapped;
          hold_vld_d  = 1'b1;
          hold_sop_d  = sop_pend_q;
          sop_pend_d  = 1'b0;
          if (!is_data) begin
            err_acc_d = 1'b1;
          end
        end
      end
      ST_FLUSH: begin
        emit       = 1'b1;
        emit_eop   = 1'b1;
        emit_err   = err_acc_q;
        emit_mod   = flush_mod_q;
        hold_vld_d = 1'b0;
        err_acc_d  = 1'b0;
        state_d    = ST_IDLE;
        // This cycle's input still gets looked at, so back-to-back packets work
        idle_in    = 1'b1;
      end
      default: begin
        idle_in = 1'b1;
      end
    endcase

    if (idle_in) begin
      if (is_start_ok) begin
        state_d    = ST_DATA;
        sop_pend_d = 1'b1;
        hold_vld_d = 1'b0;
        err_acc_d  = 1'b0;
      end else if (is_start_pat) begin
        extra_err = 1'b1;
      end
    end
  end

  // Output word and counters
  always_comb begin
    val_d  = emit;
    sop_d  = sop_q;
    eop_d  = eop_q;
    mod_d  = mod_q;
    data_d = data_q;
    err_d  = err_q;
    if (emit) begin
      sop_d  = hold_sop_q;
      eop_d  = emit_eop;
      mod_d  = emit_eop ? emit_mod : 3'd0;
      err_d  = emit_eop & emit_err;
      data_d = hold_data_q;
    end
    // A FLUSH eop with error and a bad Start in the same cycle count as two events
    err_inc   = {1'b0, emit & emit_eop & emit_err} + {1'b0, extra_err};
    pkt_inc   = emit & emit_eop & ~emit_err;
    pkt_cnt_d = sat_add(pkt_cnt_q, {1'b0, pkt_inc});
    err_cnt_d = sat_add(err_cnt_q, err_inc);
  end

  always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
    if (!reset_156m25_n) begin
      state_q     <= ST_IDLE;
      hold_data_q <= '0;
      hold_vld_q  <= 1'b0;
      hold_sop_q  <= 1'b0;
      sop_pend_q  <= 1'b0;
      err_acc_q   <= 1'b0;
      flush_mod_q <= '0;
      val_q       <= 1'b0;
      sop_q       <= 1'b0;
      eop_q       <= 1'b0;
      mod_q       <= '0;
      data_q      <= '0;
      err_q       <= 1'b0;
      pkt_cnt_q   <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      hold_data_q <= hold_data_d;
      hold_vld_q  <= hold_vld_d;
      hold_sop_q  <= hold_sop_d;
      sop_pend_q  <= sop_pend_d;
      err_acc_q   <= err_acc_d;
      flush_mod_q <= flush_mod_d;
      val_q       <= val_d;
      sop_q       <= sop_d;
      eop_q       <= eop_d;
      mod_q       <= mod_d;
      data_q      <= data_d;
      err_q       <= err_d;
      pkt_cnt_q   <= pkt_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign bus.pkt_rx_val  = val_q;
  assign bus.pkt_rx_sop  = sop_q;
  assign bus.pkt_rx_eop  = eop_q;
  assign bus.pkt_rx_mod  = mod_q;
  assign bus.pkt_rx_data = data_q;
  assign bus.pkt_rx_err  = err_q;
  assign bus.pkt_cnt     = pkt_cnt_q;
  assign bus.err_cnt     = err_cnt_q;

endmodule
